alu_req_arbiter: RTL
====================

// Module: alu_req_arbiter
// PURPOSE
//   Shares one 4-bit ALU (6 function codes, 8-bit result) between two requesters.
//   Round-robin grant; registered operands drive the ALU; result captured after a settle count.
//   Result returned over a valid/ready response port with requester ID; sits between board-level control and the ALU.
// PARAMETERS
//   DATA_W         4  operand width (A, B)
//   FUNC_W         3  ALU function-code width
//   RES_W          8  ALU result width
//   SETTLE_CYCLES  1  cycles operands are held on alu_* before capture; legal >=1
// PORTS
//   clk         in   1       clock; all state on rising edge
//   reset       in   1       synchronous, active-high reset
//   r0_valid    in   1       requester 0 has an operation
//   r0_ready    out  1       requester 0 accepted this cycle
//   r0_a, r0_b  in   DATA_W  requester 0 operands
//   r0_func     in   FUNC_W  requester 0 function code
//   r1_*        (same set as r0_*, requester 1)
//   rsp_valid   out  1       response holding
//   rsp_ready   in   1       consumer takes response
//   rsp_data    out  RES_W   captured ALU result
//   rsp_id      out  1       requester that issued the operation
//   rsp_err     out  1       illegal function code (macro only; else 0)
//   alu_a/alu_b out  DATA_W  registered operands to ALU
//   alu_func    out  FUNC_W  registered function code to ALU
//   alu_result  in   RES_W   combinational ALU output
//   busy        out  1       state != IDLE
// BEHAVIOUR
//   Reset: state IDLE, rr pointer=0 (r0 priority), all registered outputs 0; rX_ready forced 0 while reset=1.
//   FSM: IDLE -> SETTLE -> RESP -> IDLE.
//   IDLE: rX_ready combinational. Only valid requester gets ready; both valid -> pointer's requester.
//     Handshake (valid&ready) at T: latch a/b/func into alu_*; latch rsp_id; pointer <= ~granted id;
//     cnt <= SETTLE_CYCLES-1; go SETTLE.
//   SETTLE: both ready=0. cnt==0 -> rsp_data<=alu_result, rsp_valid<=1, go RESP; else cnt--.
//     With SETTLE_CYCLES=1: alu_* valid T+1, rsp_valid at T+2.
//   RESP: rsp_valid/data/id/err stable until rsp_ready=1; on handshake rsp_valid<=0, go IDLE.
//     No accept in RESP cycle; next accept earliest following cycle.
//   alu_* hold last operands until next grant.
//   Operands sampled only on handshake. Requester holds valid until ready.
//   Reset mid-op (any state): pending op dropped; outputs and pointer return to reset values next cycle.
// CONFIGURATION
//   ALU_ARB_ILLEGAL_OP_EN defined: func 3'b110/3'b111 accepted, then IDLE -> RESP directly.
//     Response: rsp_err=1, rsp_data=0, response at T+1. alu_* not updated.
//   Not defined: those codes issue like any other (ALU returns 0); rsp_err tied 0.
// STRUCTURE
//   Package alu_arb_pkg:
//     FUNC_INC=000, FUNC_ADD=001, FUNC_ADD_OP=010, FUNC_XOR_OR=011, FUNC_RED_OR=100, FUNC_CONCAT=101
//     FSM state enum IDLE/SETTLE/RESP; width constants.
//   Sub-module rr_arbiter2: valid[1:0], pointer -> one-hot grant.
// TESTING (bench instantiates the team ALU on alu_* / alu_result)
//   1 r0 func=001 a=3 b=5, rsp_ready=1 -> rsp_valid at T+2, rsp_data=0x08, rsp_id=0, busy 2 cycles.
//   2 Both valid: r0 (101,3,C), r1 (011,A,5), continuously reissued -> order id0,id1,id0;
//     data 0x3C, 0xFF, 0x3C.
//   3 rsp_ready=0 for 5 cycles -> rsp_valid/data stable, r0_ready=r1_ready=0, busy=1; release -> IDLE next cycle.
//   4 SETTLE_CYCLES=3, r1 func=000 a=F -> alu_a=F held T+1..T+3, rsp_data=0x10 at T+4, rsp_id=1.
//   5 reset=1 during SETTLE -> next cycle all outputs 0, pointer=0;
//     then simultaneous requests -> r0 first.
//   6 func=110: with ALU_ARB_ILLEGAL_OP_EN -> rsp_err=1, data 0x00 at T+1, alu_func unchanged;
//     without -> err=0, data 0x00 at T+2.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared widths, ALU function codes, FSM state codes and illegal-code helper
package alu_arb_pkg;
    localparam int DATA_W_DEF = 4;
    localparam int FUNC_W_DEF = 3;
    localparam int RES_W_DEF  = 8;
    localparam logic [2:0] FUNC_INC    = 3'b000;
    localparam logic [2:0] FUNC_ADD    = 3'b001;
    localparam logic [2:0] FUNC_ADD_OP = 3'b010;
    localparam logic [2:0] FUNC_XOR_OR = 3'b011;
    localparam logic [2:0] FUNC_RED_OR = 3'b100;
    localparam logic [2:0] FUNC_CONCAT = 3'b101;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    function automatic logic func_illegal(input logic [2:0] f);
        return f[2] & f[1];
    endfunction
endpackage

// File: rtl/alu_req_arbiter_rr.sv
// rr_arbiter2: two-way round-robin grant; pointer picks the winner only on contention
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);
    assign grant = (valid == 2'b11) ? (ptr ? 2'b10 : 2'b01) : valid;
endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one ALU between two requesters; optional ALU_ARB_ILLEGAL_OP_EN rejects func 110/111
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int FUNC_W        = FUNC_W_DEF,
    parameter int RES_W         = RES_W_DEF,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic [FUNC_W-1:0] r0_func,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    input  logic [FUNC_W-1:0] r1_func,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_data,
    output logic              rsp_id,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [FUNC_W-1:0] alu_func,
    input  logic [RES_W-1:0]  alu_result,
    output logic              busy
);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ptr_q, ptr_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [FUNC_W-1:0] alu_func_q, alu_func_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [RES_W-1:0]  rsp_data_q, rsp_data_d;
    logic              rsp_id_q, rsp_id_d;
    logic              rsp_err_q, rsp_err_d;
    logic [1:0]        grant;
    logic              idle, hs, gid, illegal;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [FUNC_W-1:0] sel_func;

    rr_arbiter2 u_arb (
        .valid ({r1_valid, r0_valid}),
        .ptr   (ptr_q),
        .grant (grant)
    );

    assign idle     = (state_q == ST_IDLE) && !reset;
    assign r0_ready = idle && grant[0];
    assign r1_ready = idle && grant[1];
    assign hs       = (r0_valid && r0_ready) || (r1_valid && r1_ready);
    assign gid      = grant[1];
    assign sel_a    = gid ? r1_a : r0_a;
    assign sel_b    = gid ? r1_b : r0_b;
    assign sel_func = gid ? r1_func : r0_func;

`ifdef ALU_ARB_ILLEGAL_OP_EN
    assign illegal = func_illegal(3'(sel_func));
`else
    assign illegal = 1'b0;
`endif

    // next-state: accept in IDLE, count down while ALU settles, hold response until taken
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_func_d  = alu_func_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    rsp_id_d = gid;
                    ptr_d    = ~gid;
                    if (illegal) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        alu_a_d    = sel_a;
                        alu_b_d    = sel_b;
                        alu_func_d = sel_func;
                        rsp_err_d  = 1'b0;
                        cnt_d      = CNT_W'(SETTLE_CYCLES - 1);
                        state_d    = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = alu_result;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state registers; reset drops any pending operation
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ptr_q       <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_func_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_func_q  <= alu_func_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_func  = alu_func_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = state_q != ST_IDLE;
endmodule
